kyber_op_scheduler: RTL and testbench
=====================================

KYBER_OP_SCHEDULER -- requirements
Module: kyber_op_scheduler

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 1000000, meaning the maximum RUN-state cycles before the watchdog aborts an operation.
REQ-002 SHALL have parameter OPW, default 2, meaning the width of the operation code.
REQ-003 SHALL have one clock and a synchronous, active-high reset: ACLK  in  1  clock, all logic on its rising edge.
REQ-004 SHALL have port ARESET  in  1  synchronous active-high reset.
REQ-005 SHALL have ports req0_valid  in  1 and req1_valid  in  1  operation request from register port S00 / S01.
REQ-006 SHALL have ports req0_op  in  OPW and req1_op  in  OPW  opcode: 00 keygen, 01 encaps, 10 decaps, 11 illegal.
REQ-007 SHALL have ports req0_ready  out  1 and req1_ready  out  1  request accepted this cycle.
REQ-008 SHALL have ports rsp0_valid  out  1 and rsp1_valid  out  1  completion pending for that port.
REQ-009 SHALL have ports rsp0_status  out  2 and rsp1_status  out  2  status: 00 ok, 01 illegal op, 10 timeout.
REQ-010 SHALL have ports rsp0_ack  in  1 and rsp1_ack  in  1  completion consumed.
REQ-011 SHALL have ports core_start  out  1  one-cycle start pulse to the shared CCAKEM core, and core_op  out  OPW  opcode to the core.
REQ-012 SHALL have ports core_done  in  1  core completion pulse, and core_abort  out  1  core abort pulse.
REQ-013 SHALL have ports owner  out  1  index of the port owning core memories, and busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, RUN, RESP.
REQ-015 IDLE: if exactly one reqN_valid is high, SHALL grant N; if both are high, SHALL grant the port not equal to last_grant.
REQ-016 reqN_ready SHALL be high combinationally only in IDLE, for the granted port only, and only while its valid is high.
REQ-017 On grant, SHALL latch the opcode and owner and move to ISSUE, or to RESP with status 01 if the opcode is 11, never asserting core_start.
REQ-018 ISSUE SHALL assert core_start for exactly one cycle with core_op equal to the latched opcode, then move to RUN.
REQ-019 RUN SHALL move to RESP with status 00 on core_done; core_done in any other state SHALL be ignored.
REQ-020 RESP SHALL hold rspN_valid and rspN_status for the owner until rspN_ack; then it SHALL update last_grant to owner and return to IDLE.
REQ-021 rspN_ack while rspN_valid is low SHALL be ignored; the non-owner's rsp outputs SHALL remain 0.
REQ-022 owner SHALL remain stable from grant until the return to IDLE.
REQ-023 Minimum latency: core_start one cycle after ready; rsp_valid one cycle after core_done; a new grant no earlier than one cycle after ack.

Reset
REQ-024 ARESET SHALL force state IDLE, last_grant=1 (port 0 wins the first tie), owner=0, and all outputs 0, including during ISSUE/RUN/RESP.
REQ-025 A reset during RUN SHALL NOT generate core_abort; the core is reset by the same ARESET.

Configuration
REQ-026 Macro KYBER_SCHED_WATCHDOG_EN defined: a counter SHALL clear on entering RUN and increment each RUN cycle.
REQ-027 With the macro, when the count reaches WDOG_CYCLES without core_done, the block SHALL pulse core_abort for one cycle and go to RESP with status 10.
REQ-028 With the macro, core_done in the same cycle as the timeout SHALL win and yield status 00.
REQ-029 Macro undefined: the counter SHALL be absent, core_abort SHALL be tied 0, and RUN SHALL wait indefinitely.

Verification
REQ-030 Scenario: req0 op=01 alone -> req0_ready cycle T, core_start/core_op=01 at T+1; core_done at T+20 -> rsp0_valid=1, status 00 at T+21 until ack.
REQ-031 Scenario: req0 and req1 both valid after reset -> port 0 granted first; after ack, port 1 granted next, never core_start overlap.
REQ-032 Scenario: req1 op=11 -> req1_ready, no core_start, rsp1_status=01 next cycle.
REQ-033 Scenario: with KYBER_SCHED_WATCHDOG_EN and WDOG_CYCLES=16, no core_done -> core_abort pulse and rsp status 10 after 16 RUN cycles; core_done at cycle 16 -> status 00, no abort.
REQ-034 Scenario: ARESET asserted mid-RUN -> next cycle all outputs 0, busy=0; a stale core_done afterwards is ignored.
REQ-035 Scenario: spurious rsp0_ack and core_done in IDLE -> no state change, all outputs remain 0.

Source files
------------

// File: rtl/kyber_op_scheduler.sv
// Two-port arbiter/sequencer in front of the shared CCAKEM core: grant, issue, run, respond.
// Optional watchdog abort is compiled in with the KYBER_SCHED_WATCHDOG_EN macro.
module kyber_op_scheduler #(
  parameter int WDOG_CYCLES = 1000000,
  parameter int OPW         = 2
) (
  input  logic           ACLK,
  input  logic           ARESET,
  input  logic           req0_valid,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req0_op,
  input  logic [OPW-1:0] req1_op,
  output logic           req0_ready,
  output logic           req1_ready,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [1:0]     rsp0_status,
  output logic [1:0]     rsp1_status,
  input  logic           rsp0_ack,
  input  logic           rsp1_ack,
  output logic           core_start,
  output logic [OPW-1:0] core_op,
  input  logic           core_done,
  output logic           core_abort,
  output logic           owner,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  state_t         state_reg, state_next;
  logic           last_grant_reg, last_grant_next;
  logic           owner_reg, owner_next;
  logic [OPW-1:0] op_reg, op_next;
  logic [1:0]     status_reg, status_next;
  logic           grant;
  logic [OPW-1:0] grant_op;
  logic           ack_owner;
  logic           timeout;

  // On a tie the port that did not win last time is served.
  assign grant     = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
  assign grant_op  = grant ? req1_op : req0_op;
  assign ack_owner = owner_reg ? rsp1_ack : rsp0_ack;

`ifdef KYBER_SCHED_WATCHDOG_EN
  localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
  logic [CW-1:0] wdog_reg;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wdog_reg <= '0;
    end else if (state_reg == ISSUE) begin
      wdog_reg <= '0;
    end else if (state_reg == RUN) begin
      wdog_reg <= wdog_reg + 1'b1;
    end
  end

  // Fires on the WDOG_CYCLES-th RUN cycle; a simultaneous core_done takes priority.
  assign timeout    = (state_reg == RUN) && (wdog_reg == CW'(WDOG_CYCLES - 1));
  assign core_abort = timeout && !core_done && !ARESET;
`else
  assign timeout    = 1'b0;
  assign core_abort = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      op_reg         <= '0;
      status_reg     <= ST_OK;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      op_reg         <= op_next;
      status_reg     <= status_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    op_next         = op_reg;
    status_next     = status_reg;
    case (state_reg)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_next = grant;
          op_next    = grant_op;
          if (grant_op == '1) begin
            state_next  = RESP;
            status_next = ST_ILLEGAL;
          end else begin
            state_next  = ISSUE;
            status_next = ST_OK;
          end
        end
      end
      ISSUE: state_next = RUN;
      RUN: begin
        if (core_done) begin
          state_next  = RESP;
          status_next = ST_OK;
        end else if (timeout) begin
          state_next  = RESP;
          status_next = ST_TIMEOUT;
        end
      end
      RESP: begin
        if (ack_owner) begin
          state_next      = IDLE;
          last_grant_next = owner_reg;
          owner_next      = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req0_ready  = (state_reg == IDLE) && !ARESET && req0_valid && !grant;
  assign req1_ready  = (state_reg == IDLE) && !ARESET && req1_valid && grant;
  assign rsp0_valid  = (state_reg == RESP) && !owner_reg;
  assign rsp1_valid  = (state_reg == RESP) && owner_reg;
  assign rsp0_status = rsp0_valid ? status_reg : 2'b00;
  assign rsp1_status = rsp1_valid ? status_reg : 2'b00;
  assign core_start  = (state_reg == ISSUE);
  assign core_op     = core_start ? op_reg : '0;
  assign owner       = owner_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_kyber_op_scheduler.sv
// Directed plus randomized transactions against a transaction-level model of the scheduler.
// Build with KYBER_SCHED_WATCHDOG_EN defined to exercise the 16-cycle watchdog.
module tb_kyber_op_scheduler;

`ifdef KYBER_SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int WDOG = 16;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_op, req1_op;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [1:0] rsp0_status, rsp1_status;
  logic       rsp0_ack, rsp1_ack;
  logic       core_start;
  logic [1:0] core_op;
  logic       core_done;
  logic       core_abort;
  logic       owner;
  logic       busy;
  logic [13:0] outvec;

  int checks = 0;
  int errors = 0;
  logic m_last;  // model: port that won the previous grant

  kyber_op_scheduler #(.WDOG_CYCLES(WDOG), .OPW(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_status(rsp0_status), .rsp1_status(rsp1_status),
    .rsp0_ack(rsp0_ack), .rsp1_ack(rsp1_ack),
    .core_start(core_start), .core_op(core_op), .core_done(core_done),
    .core_abort(core_abort), .owner(owner), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  assign outvec = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_status, rsp1_status,
                   core_start, core_op, core_abort, owner, busy};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    rsp0_ack = 0; rsp1_ack = 0; core_done = 0;
  endtask

  // done_at: RUN cycle (1-based) in which core_done pulses; ack_dly: RESP cycles before ack.
  task automatic do_txn(input logic v0, input logic v1, input logic [1:0] o0, input logic [1:0] o1,
                        input int done_at, input int ack_dly);
    logic g;
    logic [1:0] op, st;
    bit tmo;
    g   = (v0 && v1) ? ~m_last : v1;
    op  = g ? o1 : o0;
    tmo = WD && (done_at > WDOG);
    st  = (op == 2'b11) ? 2'd1 : (tmo ? 2'd2 : 2'd0);
    req0_valid = v0; req1_valid = v1; req0_op = o0; req1_op = o1;
    #1;
    chk("ready0", req0_ready, v0 && !g);
    chk("ready1", req1_ready, v1 && g);
    chk("busy_idle", busy, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    core_done = 1'($urandom_range(0, 1));
    #1;
    chk("owner_grant", owner, g);
    chk("busy_grant", busy, 1);
    if (op != 2'b11) begin
      chk("core_start", core_start, 1);
      chk("core_op", core_op, op);
      chk("rsp_issue", {rsp0_valid, rsp1_valid}, 0);
      tick();
      core_done = 0;
      for (int k = 1; k <= 64; k++) begin
        core_done = (k == done_at);
        #1;
        chk("start_run", core_start, 0);
        chk("rsp_run", {rsp0_valid, rsp1_valid}, 0);
        chk("abort_run", core_abort, tmo && (k == WDOG));
        chk("owner_run", owner, g);
        tick();
        core_done = 0;
        if (k == done_at || (WD && k == WDOG)) break;
      end
    end else begin
      chk("illegal_nostart", core_start, 0);
    end
    for (int d = 0; d <= ack_dly; d++) begin
      if (g) begin
        rsp1_ack = (d == ack_dly); rsp0_ack = 1'($urandom_range(0, 1));
      end else begin
        rsp0_ack = (d == ack_dly); rsp1_ack = 1'($urandom_range(0, 1));
      end
      core_done = 1'($urandom_range(0, 1));
      #1;
      chk("rsp_valid", {rsp0_valid, rsp1_valid}, g ? 2'b01 : 2'b10);
      chk("rsp_status", g ? rsp1_status : rsp0_status, st);
      chk("rsp_other_status", g ? rsp0_status : rsp1_status, 0);
      chk("resp_quiet", {core_start, core_abort}, 0);
      chk("owner_resp", owner, g);
      tick();
      rsp0_ack = 0; rsp1_ack = 0; core_done = 0;
    end
    m_last = g;
    #1;
    chk("back_idle", outvec, 0);
    $display("txn v=%b%b op0=%0d op1=%0d grant=%0d status=%0d done_at=%0d ack_dly=%0d",
             v0, v1, o0, o1, g, st, done_at, ack_dly);
  endtask

  initial begin
    #500000;
    $display("FAIL bench_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    clear_inputs();
    ARESET = 1;
    m_last = 1'b1;
    repeat (3) tick();
    #1;
    chk("reset_outputs", outvec, 0);
    ARESET = 0;
    tick();

    // spurious ack and core_done while idle
    rsp0_ack = 1; rsp1_ack = 1; core_done = 1;
    #1;
    chk("spurious_idle", outvec, 0);
    tick();
    clear_inputs();
    #1;
    chk("spurious_after", outvec, 0);

    // tie after reset: port 0 then port 1
    do_txn(1, 1, 2'd0, 2'd2, 5, 1);
    do_txn(1, 1, 2'd0, 2'd2, 7, 0);
    // single request, done 20 cycles after ready (shorter under the watchdog)
    do_txn(1, 0, 2'd1, 2'd0, WD ? 12 : 19, 2);
    // illegal opcode on port 1
    do_txn(0, 1, 2'd0, 2'd3, 1, 0);
    if (WD) begin
      do_txn(1, 0, 2'd2, 2'd0, 40, 1);    // timeout
      do_txn(0, 1, 2'd0, 2'd1, WDOG, 0);  // done coincides with timeout
    end

    for (int i = 0; i < 30; i++) begin
      logic [1:0] vv;
      vv = 2'($urandom_range(1, 3));
      do_txn(vv[0], vv[1], 2'($urandom), 2'($urandom),
             int'($urandom_range(1, WD ? 24 : 12)), int'($urandom_range(0, 3)));
    end

    // reset in the middle of RUN
    req0_valid = 1; req0_op = 2'd2;
    #1;
    tick();
    req0_valid = 0;
    tick();
    tick();
    #1;
    chk("pre_reset_busy", busy, 1);
    ARESET = 1;
    tick();
    ARESET = 0;
    #1;
    chk("reset_run_outputs", outvec, 0);
    m_last = 1'b1;
    core_done = 1;
    tick();
    core_done = 0;
    #1;
    chk("stale_done", outvec, 0);
    do_txn(1, 1, 2'd1, 2'd1, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
